// File: rtl/acs_pm_unit.sv
// Add-compare-select with path-metric storage for the K=3 (7,5) hard-decision Viterbi decoder.
// Optional VIT_ACS_NORM_EN: subtract 2**(PM_W-1) when all metrics exceed it; otherwise saturate.
module acs_pm_unit #(
    parameter int PM_W    = 6,
    parameter int INIT_PM = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              frame_start,
    input  logic [1:0]        bm00,
    input  logic [1:0]        bm01,
    input  logic [1:0]        bm10,
    input  logic [1:0]        bm11,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [3:0]        dec_bits,
    output logic [1:0]        best_state,
    output logic [4*PM_W-1:0] pm_flat
);

    localparam logic [PM_W-1:0]       INIT     = PM_W'(INIT_PM);
    localparam logic [PM_W-1:0]       PM_MAX   = '1;
    localparam logic [3:0][PM_W-1:0]  PM_RESET = {INIT, INIT, INIT, {PM_W{1'b0}}};
`ifdef VIT_ACS_NORM_EN
    localparam logic [PM_W:0]         HALF     = (PM_W+1)'(2 ** (PM_W - 1));
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_nxt;
    logic [3:0][PM_W-1:0]   pm_q, old_pm, new_pm, pm_flat_q;
    logic [3:0][1:0]        bm;
    logic [3:0][PM_W:0]     cand0, cand1, sel;
    logic [3:0]             dec_nxt;
    logic [1:0]             best_nxt;
    logic [1:0]             nsb;
    logic [1:0]             p0, p1;
    logic [PM_W-1:0]        min_pm;
    logic                   accept, use_init;
`ifdef VIT_ACS_NORM_EN
    logic                   norm;
    logic [3:0][PM_W:0]     adj;
`endif

    function automatic logic [1:0] code_pair(input logic u, input logic [1:0] p);
        return {u ^ p[1] ^ p[0], u ^ p[0]};
    endfunction

    function automatic logic [PM_W-1:0] sat(input logic [PM_W:0] v);
        return v[PM_W] ? PM_MAX : v[PM_W-1:0];
    endfunction

    assign bm       = {bm11, bm10, bm01, bm00};
    assign in_ready = ~dec_valid | dec_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // In IDLE the registers already hold the reset metrics, so selecting them here is equivalent.
    assign use_init = frame_start | (state_q == IDLE);
    assign old_pm   = use_init ? PM_RESET : pm_q;

    always_comb begin
        cand0   = '0;
        cand1   = '0;
        sel     = '0;
        dec_nxt = '0;
        nsb     = '0;
        p0      = '0;
        p1      = '0;
        for (int unsigned ns = 0; ns < 4; ns++) begin
            nsb          = 2'(ns);
            p0           = {nsb[0], 1'b0};
            p1           = {nsb[0], 1'b1};
            cand0[nsb]   = {1'b0, old_pm[p0]} + (PM_W+1)'(bm[code_pair(nsb[1], p0)]);
            cand1[nsb]   = {1'b0, old_pm[p1]} + (PM_W+1)'(bm[code_pair(nsb[1], p1)]);
            dec_nxt[nsb] = cand1[nsb] < cand0[nsb];
            sel[nsb]     = dec_nxt[nsb] ? cand1[nsb] : cand0[nsb];
        end
    end

`ifdef VIT_ACS_NORM_EN
    always_comb begin
        norm = 1'b1;
        adj  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (sel[k] < HALF) norm = 1'b0;
        end
        for (int unsigned k = 0; k < 4; k++) begin
            adj[k]    = norm ? sel[k] - HALF : sel[k];
            new_pm[k] = sat(adj[k]);
        end
    end
`else
    always_comb begin
        new_pm = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            new_pm[k] = sat(sel[k]);
        end
    end
`endif

    always_comb begin
        best_nxt = '0;
        min_pm   = new_pm[0];
        for (int unsigned k = 1; k < 4; k++) begin
            if (new_pm[k] < min_pm) begin
                min_pm   = new_pm[k];
                best_nxt = 2'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pm_q       <= PM_RESET;
            pm_flat_q  <= '0;
            dec_valid  <= 1'b0;
            dec_bits   <= '0;
            best_state <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                pm_q       <= new_pm;
                pm_flat_q  <= new_pm;
                dec_valid  <= 1'b1;
                dec_bits   <= dec_nxt;
                best_state <= best_nxt;
            end else if (dec_ready) begin
                dec_valid  <= 1'b0;
            end
        end
    end

    assign pm_flat = pm_flat_q;

endmodule
